// File: rtl/lcd_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_msg_sequencer
//  Description : Arbitrates between the success and fail message requesters,
//                then clears the character LCD and writes the granted message
//                from an internal ROM, one character at a time, with setup,
//                enable-pulse and hold timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_msg_sequencer #(
    parameter int EN_HIGH  = 4,
    parameter int EN_GAP   = 8,
    parameter int CLR_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset_not,
    input  logic       req_success,
    input  logic       req_fail,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_enable
);

    localparam int c_CNT_MAX_A = (EN_HIGH > EN_GAP) ? EN_HIGH : EN_GAP;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > CLR_WAIT) ? c_CNT_MAX_A : CLR_WAIT;
    localparam int c_CW        = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CW-1:0] c_EN_HIGH_LAST  = c_CW'(EN_HIGH - 1);
    localparam logic [c_CW-1:0] c_EN_GAP_LAST   = c_CW'(EN_GAP - 1);
    localparam logic [c_CW-1:0] c_CLR_WAIT_LAST = c_CW'(CLR_WAIT - 1);
    localparam logic [7:0]      c_CMD_CLEAR     = 8'h01;
    localparam logic [2:0]      c_SUCCESS_LAST  = 3'd6;
    localparam logic [2:0]      c_FAIL_LAST     = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLR_SETUP = 3'd1,
        S_CLR_PULSE = 3'd2,
        S_CLR_WAIT  = 3'd3,
        S_CH_SETUP  = 3'd4,
        S_CH_PULSE  = 3'd5,
        S_CH_GAP    = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t          r_state, w_state_next;
    logic [c_CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_idx, w_idx_next;
    logic [1:0]      r_grant, w_grant_next;
    logic            r_last_fail, w_last_fail_next;
    logic [7:0]      r_lcd_data, w_lcd_data_next;
    logic            r_lcd_rs, w_lcd_rs_next;

    // Message ROM: sel_fail picks the "Fail" text, otherwise "Success"
    function automatic logic [7:0] f_rom(input logic sel_fail, input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (sel_fail) begin
            case (idx)
                3'd0:    v = 8'h46;
                3'd1:    v = 8'h61;
                3'd2:    v = 8'h69;
                3'd3:    v = 8'h6C;
                default: v = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    v = 8'h53;
                3'd1:    v = 8'h75;
                3'd2:    v = 8'h63;
                3'd3:    v = 8'h63;
                3'd4:    v = 8'h65;
                3'd5:    v = 8'h73;
                3'd6:    v = 8'h73;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // State, counters and latched LCD bus; reset abandons any message in flight
    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_grant     <= 2'b00;
            r_last_fail <= 1'b1;
            r_lcd_data  <= 8'h00;
            r_lcd_rs    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_grant     <= w_grant_next;
            r_last_fail <= w_last_fail_next;
            r_lcd_data  <= w_lcd_data_next;
            r_lcd_rs    <= w_lcd_rs_next;
        end
    end

    // Next-state logic; LCD data/RS are only reloaded on entry to a SETUP state
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_grant_next     = r_grant;
        w_last_fail_next = r_last_fail;
        w_lcd_data_next  = r_lcd_data;
        w_lcd_rs_next    = r_lcd_rs;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (req_success || req_fail) begin
                    // On a tie, serve whichever side did not own the LCD last
                    if (req_success && (!req_fail || r_last_fail)) begin
                        w_grant_next = 2'b01;
                    end else begin
                        w_grant_next = 2'b10;
                    end
                    w_lcd_data_next = c_CMD_CLEAR;
                    w_lcd_rs_next   = 1'b0;
                    w_state_next    = S_CLR_SETUP;
                end
            end
            S_CLR_SETUP: begin
                w_cnt_next   = '0;
                w_state_next = S_CLR_PULSE;
            end
            S_CLR_PULSE: begin
                if (r_cnt == c_EN_HIGH_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_CLR_WAIT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_CLR_WAIT: begin
                if (r_cnt == c_CLR_WAIT_LAST) begin
                    w_cnt_next      = '0;
                    w_idx_next      = 3'd0;
                    w_lcd_data_next = f_rom(r_grant[1], 3'd0);
                    w_lcd_rs_next   = 1'b1;
                    w_state_next    = S_CH_SETUP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_CH_SETUP: begin
                w_cnt_next   = '0;
                w_state_next = S_CH_PULSE;
            end
            S_CH_PULSE: begin
                if (r_cnt == c_EN_HIGH_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_CH_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_CH_GAP: begin
                if (r_cnt == c_EN_GAP_LAST) begin
                    w_cnt_next = '0;
                    if (r_idx == (r_grant[1] ? c_FAIL_LAST : c_SUCCESS_LAST)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_idx_next      = r_idx + 3'd1;
                        w_lcd_data_next = f_rom(r_grant[1], r_idx + 3'd1);
                        w_lcd_rs_next   = 1'b1;
                        w_state_next    = S_CH_SETUP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_last_fail_next = r_grant[1];
                w_grant_next     = 2'b00;
                w_idx_next       = 3'd0;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign lcd_data   = r_lcd_data;
    assign lcd_rs     = r_lcd_rs;
    assign lcd_enable = (r_state == S_CLR_PULSE) || (r_state == S_CH_PULSE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_msg_sequencer
//  Description : Directed self-checking bench for lcd_msg_sequencer, covering
//                a default-timing instance and a minimum-timing instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_msg_sequencer;

    logic       clk;
    logic       reset_not;
    logic       a_req_s, a_req_f;
    logic [1:0] a_grant;
    logic       a_busy, a_done, a_rs, a_en;
    logic [7:0] a_data;
    logic       b_req_s, b_req_f;
    logic [1:0] b_grant;
    logic       b_busy, b_done, b_rs, b_en;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_data [0:15];
    logic       cap_rs   [0:15];

    logic [7:0] exp_s [0:7] = '{8'h01, 8'h53, 8'h75, 8'h63, 8'h63, 8'h65, 8'h73, 8'h73};
    logic [7:0] exp_f [0:4] = '{8'h01, 8'h46, 8'h61, 8'h69, 8'h6C};

    lcd_msg_sequencer u_dut_a (
        .clk         (clk),
        .reset_not   (reset_not),
        .req_success (a_req_s),
        .req_fail    (a_req_f),
        .grant       (a_grant),
        .busy        (a_busy),
        .done        (a_done),
        .lcd_data    (a_data),
        .lcd_rs      (a_rs),
        .lcd_enable  (a_en)
    );

    lcd_msg_sequencer #(.EN_HIGH(1), .EN_GAP(1), .CLR_WAIT(1)) u_dut_b (
        .clk         (clk),
        .reset_not   (reset_not),
        .req_success (b_req_s),
        .req_fail    (b_req_f),
        .grant       (b_grant),
        .busy        (b_busy),
        .done        (b_done),
        .lcd_data    (b_data),
        .lcd_rs      (b_rs),
        .lcd_enable  (b_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe one message from the current (busy) negedge until busy drops
    task automatic capture(input bit sel_b, input int en_high, input int max_cyc,
                           output int busy_cyc, output int npulse, output int done_cnt,
                           output int done_at, output int bad_width, output int unstable,
                           output int gchg, output logic [1:0] g, output bit timeout);
        logic       prev_en;
        logic       c_busy, c_done, c_en, c_rs;
        logic [7:0] c_data;
        logic [1:0] c_grant;
        int         w;
        busy_cyc = 0; npulse = 0; done_cnt = 0; done_at = 0;
        bad_width = 0; unstable = 0; gchg = 0; timeout = 0;
        prev_en = 1'b0; w = 0;
        g = sel_b ? b_grant : a_grant;
        for (int i = 0; i < max_cyc; i++) begin
            c_busy  = sel_b ? b_busy  : a_busy;
            c_done  = sel_b ? b_done  : a_done;
            c_en    = sel_b ? b_en    : a_en;
            c_rs    = sel_b ? b_rs    : a_rs;
            c_data  = sel_b ? b_data  : a_data;
            c_grant = sel_b ? b_grant : a_grant;
            if (!c_busy) break;
            busy_cyc++;
            if (c_done) begin
                done_cnt++;
                done_at = busy_cyc;
            end
            if (c_grant !== g) gchg++;
            if (c_en) begin
                if (!prev_en) begin
                    if (npulse < 16) begin
                        cap_data[npulse] = c_data;
                        cap_rs[npulse]   = c_rs;
                    end
                    npulse++;
                    w = 0;
                end else if (npulse <= 16 && (c_data !== cap_data[npulse-1] || c_rs !== cap_rs[npulse-1])) begin
                    unstable++;
                end
                w++;
            end else if (prev_en && w != en_high) begin
                bad_width++;
            end
            prev_en = c_en;
            @(negedge clk);
        end
        c_busy = sel_b ? b_busy : a_busy;
        if (c_busy) timeout = 1;
    endtask

    task automatic test_reset();
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", a_grant); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", a_data); end
        checks++; if (a_rs !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", a_rs); end
        checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", a_en); end
        checks++; if (b_busy !== 1'b0 || b_en !== 1'b0) begin errors++; $display("FAIL reset_b got busy %b en %b want 0 0", b_busy, b_en); end
    endtask

    task automatic test_success();
        int bc, np, dc, da, bw, us, gc; logic [1:0] g; bit to;
        @(negedge clk); a_req_s = 1'b1;
        @(negedge clk); a_req_s = 1'b0;
        checks++; if (a_busy !== 1'b1 || a_grant !== 2'b01) begin errors++; $display("FAIL succ_accept got busy %b grant %b want 1 01", a_busy, a_grant); end
        checks++; if (a_data !== 8'h01 || a_rs !== 1'b0 || a_en !== 1'b0) begin errors++; $display("FAIL succ_clr_setup got data %h rs %b en %b want 01 0 0", a_data, a_rs, a_en); end
        capture(1'b0, 4, 300, bc, np, dc, da, bw, us, gc, g, to);
        checks++; if (to) begin errors++; $display("FAIL succ_timeout got busy stuck want release"); end
        checks++; if (bc != 113) begin errors++; $display("FAIL succ_busy_len got %0d want 113", bc); end
        checks++; if (dc != 1 || da != 113) begin errors++; $display("FAIL succ_done got count %0d at %0d want 1 at 113", dc, da); end
        checks++; if (np != 8) begin errors++; $display("FAIL succ_pulses got %0d want 8", np); end
        checks++; if (bw != 0 || us != 0 || gc != 0) begin errors++; $display("FAIL succ_timing got badwidth %0d unstable %0d grantchg %0d want 0 0 0", bw, us, gc); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (np == 8 && (cap_data[i] !== exp_s[i] || cap_rs[i] !== (i != 0))) begin
                errors++; $display("FAIL succ_byte%0d got %h rs %b want %h rs %0d", i, cap_data[i], cap_rs[i], exp_s[i], (i != 0));
            end
        end
        checks++; if (a_grant !== 2'b00 || a_busy !== 1'b0) begin errors++; $display("FAIL succ_idle got grant %b busy %b want 00 0", a_grant, a_busy); end
    endtask

    task automatic test_fail();
        int bc, np, dc, da, bw, us, gc; logic [1:0] g; bit to;
        @(negedge clk); a_req_f = 1'b1;
        @(negedge clk); a_req_f = 1'b0;
        capture(1'b0, 4, 300, bc, np, dc, da, bw, us, gc, g, to);
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL fail_grant got %b want 10", g); end
        checks++; if (to || bc != 74) begin errors++; $display("FAIL fail_busy_len got %0d timeout %0d want 74", bc, to); end
        checks++; if (dc != 1 || np != 5 || bw != 0 || us != 0) begin errors++; $display("FAIL fail_shape got done %0d pulses %0d badwidth %0d unstable %0d want 1 5 0 0", dc, np, bw, us); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (np == 5 && cap_data[i] !== exp_f[i]) begin
                errors++; $display("FAIL fail_byte%0d got %h want %h", i, cap_data[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, np, dc, da, bw, us, gc, seen; logic [1:0] g; bit to;
        logic [1:0] exp_g [0:2] = '{2'b01, 2'b10, 2'b01};
        int         exp_len [0:2] = '{113, 74, 113};
        @(negedge clk); reset_not = 1'b0;
        @(negedge clk); reset_not = 1'b1; a_req_s = 1'b1; a_req_f = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            checks++; if (a_busy !== 1'b1 || a_grant !== exp_g[m]) begin errors++; $display("FAIL b2b_grant%0d got busy %b grant %b want 1 %b", m, a_busy, a_grant, exp_g[m]); end
            if (m == 2) begin a_req_s = 1'b0; a_req_f = 1'b0; end
            capture(1'b0, 4, 300, bc, np, dc, da, bw, us, gc, g, to);
            checks++; if (to || bc != exp_len[m] || dc != 1 || gc != 0) begin errors++; $display("FAIL b2b_msg%0d got len %0d done %0d grantchg %0d want %0d 1 0", m, bc, dc, gc, exp_len[m]); end
            checks++; if (a_busy !== 1'b0 || a_grant !== 2'b00) begin errors++; $display("FAIL b2b_gap%0d got busy %b grant %b want 0 00", m, a_busy, a_grant); end
            @(negedge clk);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL b2b_stop got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_ignore_while_busy();
        int bc, np, dc, da, bw, us, gc, seen; logic [1:0] g; bit to;
        @(negedge clk); a_req_s = 1'b1;
        @(negedge clk); a_req_s = 1'b0;
        fork
            capture(1'b0, 4, 300, bc, np, dc, da, bw, us, gc, g, to);
            begin
                repeat (40) @(negedge clk);
                a_req_f = 1'b1;
                @(negedge clk);
                a_req_f = 1'b0;
            end
        join
        checks++; if (g !== 2'b01 || to || bc != 113 || np != 8 || gc != 0) begin errors++; $display("FAIL ign_msg got grant %b len %0d pulses %0d grantchg %0d want 01 113 8 0", g, bc, np, gc); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL ign_no_followup got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int rises, seen; logic prev;
        @(negedge clk); a_req_s = 1'b1;
        @(negedge clk); a_req_s = 1'b0;
        rises = 0; prev = a_en;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            @(negedge clk);
            if (a_en && !prev) rises++;
            prev = a_en;
        end
        checks++; if (rises != 4) begin errors++; $display("FAIL rmid_reach got %0d rises want 4", rises); end
        checks++; if (a_en !== 1'b1 || a_data !== 8'h63 || a_rs !== 1'b1) begin errors++; $display("FAIL rmid_third_char got en %b data %h rs %b want 1 63 1", a_en, a_data, a_rs); end
        #2 reset_not = 1'b0;
        #1;
        checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL rmid_en got %b want 0", a_en); end
        checks++; if (a_busy !== 1'b0 || a_grant !== 2'b00 || a_done !== 1'b0 || a_data !== 8'h00 || a_rs !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs got busy %b grant %b done %b data %h rs %b want 0 00 0 00 0", a_busy, a_grant, a_done, a_data, a_rs);
        end
        @(negedge clk); reset_not = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_busy || a_en) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_stay_idle got %0d active cycles want 0", seen); end
    endtask

    task automatic test_fast_params();
        int bc, np, dc, da, bw, us, gc; logic [1:0] g; bit to;
        @(negedge clk); b_req_s = 1'b1;
        @(negedge clk); b_req_s = 1'b0;
        capture(1'b1, 1, 100, bc, np, dc, da, bw, us, gc, g, to);
        checks++; if (g !== 2'b01 || to || bc != 25) begin errors++; $display("FAIL fast_busy_len got grant %b len %0d want 01 25", g, bc); end
        checks++; if (np != 8 || bw != 0 || us != 0 || dc != 1 || da != 25) begin errors++; $display("FAIL fast_shape got pulses %0d badwidth %0d unstable %0d done %0d at %0d want 8 0 0 1 25", np, bw, us, dc, da); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (np == 8 && cap_data[i] !== exp_s[i]) begin
                errors++; $display("FAIL fast_byte%0d got %h want %h", i, cap_data[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        reset_not = 1'b0;
        a_req_s = 1'b0; a_req_f = 1'b0;
        b_req_s = 1'b0; b_req_f = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_not = 1'b1;
        test_success();
        test_fail();
        test_back_to_back();
        test_ignore_while_busy();
        test_reset_mid();
        test_fast_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_msg_sequencer.md
# lcd_msg_sequencer

Controller that shares the character LCD between two message requesters (success and fail result paths) and sequences every LCD write. It clears the display and then writes the granted message one character at a time, with proper setup, enable-pulse and hold timing. The message text lives in an internal ROM. The block sits between the game/result logic and the LCD pins, and is the only driver of `lcd_data`, `lcd_rs` and `lcd_enable`.

## Interface
Parameters:
- `EN_HIGH`, default 4: cycles `lcd_enable` is held high per write (≥1).
- `EN_GAP`, default 8: cycles `lcd_enable` is held low after each character write (≥1).
- `CLR_WAIT`, default 16: cycles waited after the clear-display command (≥1).

Ports:
- `clk`, input, 1: single clock; all state changes on rising edge.
- `reset_not`, input, 1: asynchronous, active-low reset.
- `req_success`, input, 1: level request to show "Success".
- `req_fail`, input, 1: level request to show "Fail".
- `grant`, output, 2: one-hot owner; bit0 = success, bit1 = fail, 00 when idle.
- `busy`, output, 1: high from acceptance of a request through the DONE cycle.
- `done`, output, 1: 1-cycle pulse when the message is complete.
- `lcd_data`, output, 8: command or ASCII byte.
- `lcd_rs`, output, 1: 0 = command, 1 = character data.
- `lcd_enable`, output, 1: LCD write strobe.

## Operation
- ROM contents:
  - success: 0x53 0x75 0x63 0x63 0x65 0x73 0x73 ("Success", 7 chars).
  - fail: 0x46 0x61 0x69 0x6C ("Fail", 4 chars).
- States: IDLE, CLR_SETUP, CLR_PULSE, CLR_WAIT, CH_SETUP, CH_PULSE, CH_GAP, DONE.
- IDLE:
  - Requests are sampled here. If exactly one is high, grant it.
  - If both are high, round-robin: grant the requester not granted last. `last_grant` resets to fail, so success wins the first tie.
  - On a grant: latch `grant`, set `busy`, go to CLR_SETUP.
- CLR_SETUP, 1 cycle: `lcd_data`=0x01, `lcd_rs`=0, `lcd_enable`=0.
- CLR_PULSE, `EN_HIGH` cycles: `lcd_enable`=1, data unchanged.
- CLR_WAIT, `CLR_WAIT` cycles: `lcd_enable`=0, then char index := 0 and go to CH_SETUP.
- CH_SETUP, 1 cycle: `lcd_data` = ROM[grant][index], `lcd_rs`=1, `lcd_enable`=0.
- CH_PULSE, `EN_HIGH` cycles: `lcd_enable`=1.
- CH_GAP, `EN_GAP` cycles: `lcd_enable`=0. At the end:
  - if index = len−1, go to DONE;
  - otherwise index+1, go to CH_SETUP.
- DONE, 1 cycle:
  - `done`=1, `busy`=1, `lcd_enable`=0.
  - `grant` is still held and `last_grant` is updated.
  - Next state is IDLE, where `grant` returns to 00 and `busy` to 0.
- Requests arriving while busy are ignored, not queued. A level request still high on return to IDLE is re-granted; the earliest re-grant is the cycle after DONE.
- `lcd_data` and `lcd_rs` are stable across each SETUP/PULSE/GAP group. They change only on entry to a SETUP state, and hold their last value in IDLE.
- The char index is 3 bits and never exceeds len−1, so it has no wrap. The delay counter is sized for max(`EN_HIGH`, `EN_GAP`, `CLR_WAIT`).

## Timing
- Reset (async, immediate): state=IDLE; `grant`=00, `busy`=0, `done`=0, `lcd_data`=0x00, `lcd_rs`=0, `lcd_enable`=0; `last_grant`=fail; index and counter = 0.
- Reset mid-message: `lcd_enable` drops at once, the message is abandoned, and nothing resumes after release.
- Request high at edge N while in IDLE:
  - from N+1: CLR_SETUP, with `busy`=1 and `grant` valid;
  - at N+2: first `lcd_enable` rise.
- Busy duration (CLR_SETUP through DONE) = (1+`EN_HIGH`+`CLR_WAIT`) + len·(1+`EN_HIGH`+`EN_GAP`) + 1.
  - Defaults, success: 21 + 7·13 + 1 = 113 cycles.
  - Defaults, fail: 21 + 4·13 + 1 = 74 cycles.
- Number of `lcd_enable` pulses per message = len+1, each exactly `EN_HIGH` cycles.

## Test plan
- Reset then a single `req_success` pulse → `grant`=01; pulse sequence 0x01(rs0), 0x53, 0x75, 0x63, 0x63, 0x65, 0x73, 0x73 (rs1); 8 pulses of 4 cycles; `done` pulse at cycle 113 after `busy` rises.
- `req_fail` only → `grant`=10; bytes 0x01, 0x46, 0x61, 0x69, 0x6C; `busy` high for 74 cycles; one `done` pulse.
- Both requests held continuously → grants alternate success, fail, success; each message completes before the next CLR_SETUP.
- `req_fail` pulsed mid-way through a success message → ignored; success completes and no fail message follows.
- `reset_not` low during the 3rd character's CH_PULSE → same-cycle `lcd_enable`=0, all outputs at reset values; after release with no request, stays IDLE.
- Parameters `EN_HIGH`=1, `EN_GAP`=1, `CLR_WAIT`=1 → success busy = 3 + 7·3 + 1 = 25 cycles; data stable during every enable-high cycle.
